// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
// Round-robin ownership arbiter for one shared W-bit register. The current
// owner may load the register. A hold counter hands the grant on when an
// owner keeps it for MAX_HOLD cycles while another requester is waiting.

module shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 16,
    localparam int OW      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    we_i,
    input  logic [N*W-1:0]  d_i,
    output logic [N-1:0]    gnt_o,
    output logic [OW-1:0]   owner_o,
    output logic            busy_o,
    output logic [W-1:0]    q_o,
    output logic            timeout_o
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [OW-1:0] LAST_IDX  = OW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_gnt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_ptr;
    logic [HW-1:0]   r_hold;
    logic [W-1:0]    r_q;
    logic            r_timeout;

    state_t          w_stateNext;
    logic [N-1:0]    w_gntNext;
    logic [OW-1:0]   w_ownerNext;
    logic [OW-1:0]   w_ptrNext;
    logic [HW-1:0]   w_holdNext;
    logic            w_timeoutNext;

    logic [OW-1:0]   w_afterOwner;
    logic [N-1:0]    w_others;
    logic [OW-1:0]   w_idlePick;
    logic [OW-1:0]   w_busyPick;

    // Finds the first set bit of mask searching upward from start, wrapping
    // modulo N. Callers only use the result when mask is non-zero.
    function automatic logic [OW-1:0] rrPick(input logic [N-1:0] mask,
                                             input logic [OW-1:0] start);
        logic [OW-1:0] pick;
        logic [OW-1:0] idx;
        logic          found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = OW'((int'(start) + i) % N);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Converts an owner index to its one-hot grant vector.
    function automatic logic [N-1:0] toOneHot(input logic [OW-1:0] idx);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // The slot after the current owner is both the new pointer on a
    // handover and the starting point of the search for the next winner.
    assign w_afterOwner = (r_owner == LAST_IDX) ? '0 : r_owner + OW'(1);
    assign w_others     = req_i & ~toOneHot(r_owner);
    assign w_idlePick   = rrPick(req_i, r_ptr);
    assign w_busyPick   = rrPick(w_others, w_afterOwner);

    // Next-state logic: grant from idle, release/handover, preemption and
    // the saturating hold counter.
    always_comb begin
        w_stateNext   = r_state;
        w_gntNext     = r_gnt;
        w_ownerNext   = r_owner;
        w_ptrNext     = r_ptr;
        w_holdNext    = r_hold;
        w_timeoutNext = 1'b0;

        case (r_state)
            IDLE: begin
                if (|req_i) begin
                    w_stateNext = BUSY;
                    w_gntNext   = toOneHot(w_idlePick);
                    w_ownerNext = w_idlePick;
                    w_holdNext  = '0;
                end
            end

            BUSY: begin
                if (!req_i[r_owner]) begin
                    w_ptrNext  = w_afterOwner;
                    w_holdNext = '0;
                    if (|w_others) begin
                        w_gntNext   = toOneHot(w_busyPick);
                        w_ownerNext = w_busyPick;
                    end else begin
                        w_stateNext = IDLE;
                        w_gntNext   = '0;
                    end
                end else if ((r_hold == HOLD_LAST) && (|w_others)) begin
                    w_ptrNext     = w_afterOwner;
                    w_holdNext    = '0;
                    w_gntNext     = toOneHot(w_busyPick);
                    w_ownerNext   = w_busyPick;
                    w_timeoutNext = 1'b1;
                end else if (r_hold != HOLD_LAST) begin
                    w_holdNext = r_hold + HW'(1);
                end
            end

            default: begin
                w_stateNext = IDLE;
                w_gntNext   = '0;
                w_holdNext  = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_gnt     <= w_gntNext;
            r_owner   <= w_ownerNext;
            r_ptr     <= w_ptrNext;
            r_hold    <= w_holdNext;
            r_timeout <= w_timeoutNext;
        end
    end

    // Shared register: only the granted requester's write enable is honoured,
    // including on the edge where its grant is released or preempted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (r_gnt[k] && we_i[k]) begin
                    r_q <= d_i[k*W +: W];
                end
            end
        end
    end

    assign gnt_o     = r_gnt;
    assign owner_o   = r_owner;
    assign busy_o    = (r_state == BUSY);
    assign q_o       = r_q;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter with default parameters
// (N=4, W=8, MAX_HOLD=16).

module tb_shared_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_i;
    logic [3:0]  we_i;
    logic [31:0] d_i;
    logic [3:0]  gnt_o;
    logic [1:0]  owner_o;
    logic        busy_o;
    logic [7:0]  q_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(.N(4), .W(8), .MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .we_i      (we_i),
        .d_i       (d_i),
        .gnt_o     (gnt_o),
        .owner_o   (owner_o),
        .busy_o    (busy_o),
        .q_o       (q_o),
        .timeout_o (timeout_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] we,
                                 input logic [31:0] d);
        req_i = req;
        we_i  = we;
        d_i   = d;
    endtask

    // Advances n rising edges and settles 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic syncReset();
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] expG;
        logic [3:0] dropReq;

        rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 32'h0);

        // Reset values
        tick(1);
        checkOutput("rst_gnt", 32'(gnt_o), 32'h0);
        checkOutput("rst_owner", 32'(owner_o), 32'h0);
        checkOutput("rst_busy", 32'(busy_o), 32'h0);
        checkOutput("rst_q", 32'(q_o), 32'h0);
        checkOutput("rst_timeout", 32'(timeout_o), 32'h0);
        rst = 1'b0;

        // Single request from requester 2, then a write
        tick(1);
        applyStimulus(4'b0100, 4'b0000, 32'h0);
        tick(1);
        checkOutput("single_gnt", 32'(gnt_o), 32'h4);
        checkOutput("single_owner", 32'(owner_o), 32'h2);
        checkOutput("single_busy", 32'(busy_o), 32'h1);
        applyStimulus(4'b0100, 4'b0100, 32'h00A5_0000);
        tick(1);
        checkOutput("single_write_q", 32'(q_o), 32'hA5);
        applyStimulus(4'b0000, 4'b0000, 32'h0);
        tick(1);
        checkOutput("release_gnt", 32'(gnt_o), 32'h0);
        checkOutput("release_busy", 32'(busy_o), 32'h0);
        checkOutput("release_owner_held", 32'(owner_o), 32'h2);
        checkOutput("release_q_held", 32'(q_o), 32'hA5);

        // Round-robin with all four requesting, two grant cycles each
        syncReset();
        applyStimulus(4'b1111, 4'b0000, 32'h0);
        tick(1);
        checkOutput("rr_first_gnt", 32'(gnt_o), 32'h1);
        for (int k = 0; k < 4; k++) begin
            expG = 4'b0001 << k;
            tick(1);
            checkOutput("rr_hold_gnt", 32'(gnt_o), 32'(expG));
            dropReq = 4'b1111 & ~expG;
            applyStimulus(dropReq, 4'b0000, 32'h0);
            tick(1);
            expG = 4'b0001 << ((k + 1) % 4);
            checkOutput("rr_handover_gnt", 32'(gnt_o), 32'(expG));
            checkOutput("rr_handover_busy", 32'(busy_o), 32'h1);
            applyStimulus(4'b1111, 4'b0000, 32'h0);
        end

        // Preemption: requester 1 owns, requester 3 arrives in grant cycle 5
        syncReset();
        applyStimulus(4'b0010, 4'b0000, 32'h0);
        tick(1);
        checkOutput("pre_gnt1", 32'(gnt_o), 32'h2);
        tick(4);
        applyStimulus(4'b1010, 4'b0000, 32'h0);
        tick(10);
        checkOutput("pre_cycle15_gnt", 32'(gnt_o), 32'h2);
        checkOutput("pre_cycle15_timeout", 32'(timeout_o), 32'h0);
        tick(1);
        checkOutput("pre_cycle16_gnt", 32'(gnt_o), 32'h2);
        tick(1);
        checkOutput("pre_moved_gnt", 32'(gnt_o), 32'h8);
        checkOutput("pre_moved_owner", 32'(owner_o), 32'h3);
        checkOutput("pre_timeout_pulse", 32'(timeout_o), 32'h1);
        applyStimulus(4'b1000, 4'b0000, 32'h0);
        tick(1);
        checkOutput("pre_timeout_end", 32'(timeout_o), 32'h0);

        // Uncontended owner keeps the grant past the hold limit
        for (int c = 0; c < 40; c++) begin
            tick(1);
            checkOutput("uncont_timeout", 32'(timeout_o), 32'h0);
        end
        checkOutput("uncont_gnt", 32'(gnt_o), 32'h8);
        applyStimulus(4'b1001, 4'b0000, 32'h0);
        tick(1);
        checkOutput("late_pre_gnt", 32'(gnt_o), 32'h1);
        checkOutput("late_pre_timeout", 32'(timeout_o), 32'h1);
        applyStimulus(4'b0001, 4'b0000, 32'h0);
        tick(1);
        checkOutput("late_pre_timeout_end", 32'(timeout_o), 32'h0);

        // Write filtering with owner 0
        applyStimulus(4'b0001, 4'b0001, 32'h0000_0011);
        tick(1);
        checkOutput("wf_owner_write", 32'(q_o), 32'h11);
        applyStimulus(4'b0001, 4'b0100, 32'h003C_0000);
        tick(1);
        checkOutput("wf_nonowner_ignored", 32'(q_o), 32'h11);
        applyStimulus(4'b0000, 4'b0001, 32'h0000_0077);
        tick(1);
        checkOutput("wf_release_write", 32'(q_o), 32'h77);
        checkOutput("wf_release_gnt", 32'(gnt_o), 32'h0);
        checkOutput("wf_release_busy", 32'(busy_o), 32'h0);

        // Asynchronous reset while requester 3 owns and q holds 0xFF
        applyStimulus(4'b1000, 4'b0000, 32'h0);
        tick(1);
        checkOutput("ar_gnt3", 32'(gnt_o), 32'h8);
        applyStimulus(4'b1000, 4'b1000, 32'hFF00_0000);
        tick(1);
        checkOutput("ar_q_ff", 32'(q_o), 32'hFF);
        applyStimulus(4'b1000, 4'b0000, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_gnt", 32'(gnt_o), 32'h0);
        checkOutput("ar_q", 32'(q_o), 32'h0);
        checkOutput("ar_owner", 32'(owner_o), 32'h0);
        checkOutput("ar_busy", 32'(busy_o), 32'h0);
        applyStimulus(4'b1010, 4'b0000, 32'h0);
        #1;
        rst = 1'b0;
        tick(1);
        checkOutput("ar_after_gnt", 32'(gnt_o), 32'h2);
        checkOutput("ar_after_owner", 32'(owner_o), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
